// File: rtl/dcro_pkg.sv
// Shared encodings for the DCRO frequency-control-word controller.
package dcro_pkg;

  localparam logic [1:0] MODE_ABS  = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_RAMP = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

endpackage

// File: rtl/dcro_sat_clamp.sv
// Combinational saturating clamp of a signed value into [MIN_VALUE, MAX_VALUE].
module dcro_sat_clamp #(
  parameter int unsigned WIDTH     = 10,
  parameter int          MIN_VALUE = 1,
  parameter int          MAX_VALUE = 255
) (
  input  logic signed [WIDTH-1:0] x,
  output logic        [WIDTH-3:0] y,
  output logic                    hi,
  output logic                    lo
);

  localparam logic signed [WIDTH-1:0] LO_B = WIDTH'(MIN_VALUE);
  localparam logic signed [WIDTH-1:0] HI_B = WIDTH'(MAX_VALUE);

  always_comb begin
    lo = (x < LO_B);
    hi = (x > HI_B);
    y  = x[WIDTH-3:0];
    if (lo) begin
      y = LO_B[WIDTH-3:0];
    end else if (hi) begin
      y = HI_B[WIDTH-3:0];
    end
  end

endmodule

// File: rtl/dcro_fcw_ctrl.sv
// FCW controller for the DCRO: absolute/incremental/hold updates and a
// slew-limited ramp with abort, clamped to [MIN_VALUE, MAX_VALUE].
module dcro_fcw_ctrl
  import dcro_pkg::*;
#(
  parameter int unsigned SEL_LEN   = 8,
  parameter int unsigned STEP_LEN  = 4,
  parameter int          MIN_VALUE = 1,
  parameter int          MAX_VALUE = 2**SEL_LEN - 1,
  parameter int          RST_VALUE = MIN_VALUE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                mode,
  input  logic signed [SEL_LEN:0]   sel_in,
  input  logic [STEP_LEN-1:0]       max_step,
  input  logic                      abort,
  output logic [SEL_LEN-1:0]        sel_out,
  output logic                      busy,
  output logic                      sat_hi,
  output logic                      sat_lo,
  output logic                      settled
);

  localparam int unsigned CW = SEL_LEN + 2;
  localparam logic [SEL_LEN-1:0] RST_SEL = SEL_LEN'(RST_VALUE);

  state_t               state;
  logic [SEL_LEN-1:0]   target;
  logic [STEP_LEN-1:0]  step;

  logic                 accept;
  logic signed [CW-1:0] sum;
  logic signed [CW-1:0] clamp_in;
  logic [SEL_LEN-1:0]   clamped;
  logic                 clamp_hi;
  logic                 clamp_lo;

  logic [SEL_LEN-1:0]   ramp_tgt;
  logic [STEP_LEN-1:0]  ramp_step;
  logic [STEP_LEN-1:0]  first_step;
  logic signed [SEL_LEN:0] diff;
  logic [SEL_LEN:0]     mag;
  logic [SEL_LEN:0]     step_ext;
  logic [SEL_LEN:0]     move;
  logic [SEL_LEN-1:0]   ramp_next;
  logic                 reach;

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state == RAMP);
  assign accept   = in_valid && in_ready;

  assign sum      = $signed({2'b00, sel_out}) + $signed({sel_in[SEL_LEN], sel_in});
  assign clamp_in = (mode == MODE_INC) ? sum : $signed({sel_in[SEL_LEN], sel_in});

  dcro_sat_clamp #(
    .WIDTH     (CW),
    .MIN_VALUE (MIN_VALUE),
    .MAX_VALUE (MAX_VALUE)
  ) u_clamp (
    .x  (clamp_in),
    .y  (clamped),
    .hi (clamp_hi),
    .lo (clamp_lo)
  );

  // In IDLE the step engine works on the request being accepted, so the
  // first ramp step lands on the accepting edge itself.
  assign first_step = (max_step == '0) ? STEP_LEN'(1) : max_step;
  assign ramp_tgt   = (state == IDLE) ? clamped : target;
  assign ramp_step  = (state == IDLE) ? first_step : step;

  always_comb begin
    diff      = $signed({1'b0, ramp_tgt}) - $signed({1'b0, sel_out});
    mag       = diff[SEL_LEN] ? (SEL_LEN + 1)'(-diff) : diff;
    step_ext  = (SEL_LEN + 1)'(ramp_step);
    reach     = (step_ext >= mag);
    move      = reach ? mag : step_ext;
    ramp_next = diff[SEL_LEN] ? (sel_out - move[SEL_LEN-1:0])
                              : (sel_out + move[SEL_LEN-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel_out <= RST_SEL;
      target  <= RST_SEL;
      step    <= STEP_LEN'(1);
      sat_hi  <= 1'b0;
      sat_lo  <= 1'b0;
      settled <= 1'b0;
    end else begin
      sat_hi  <= 1'b0;
      sat_lo  <= 1'b0;
      settled <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (mode)
              MODE_ABS, MODE_INC: begin
                sel_out <= clamped;
                sat_hi  <= clamp_hi;
                sat_lo  <= clamp_lo;
              end
              MODE_RAMP: begin
                target  <= clamped;
                step    <= first_step;
                sel_out <= ramp_next;
                sat_hi  <= clamp_hi;
                sat_lo  <= clamp_lo;
                if (reach) begin
                  settled <= 1'b1;
                end else begin
                  state <= RAMP;
                end
              end
              MODE_HOLD: ;
              default: ;
            endcase
          end
        end
        RAMP: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            sel_out <= ramp_next;
            if (reach) begin
              state   <= IDLE;
              settled <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcro_fcw_ctrl.sv
// Scoreboard bench for dcro_fcw_ctrl: each scenario queues per-edge
// expectations with its stimulus and compares after every rising edge.
module tb_dcro_fcw_ctrl;
  import dcro_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       mode = MODE_HOLD;
  logic signed [8:0] sel_in = '0;
  logic [3:0]       max_step = '0;
  logic             abort = 1'b0;
  logic [7:0]       sel_out;
  logic             busy;
  logic             sat_hi;
  logic             sat_lo;
  logic             settled;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] sel;
    logic       ready;
    logic       busy;
    logic       hi;
    logic       lo;
    logic       settled;
  } obs_t;

  typedef struct {
    logic       v;
    logic [1:0] md;
    int         si;
    int         ms;
    logic       ab;
    logic       r;
    obs_t       e;
  } step_t;

  obs_t sb[$];

  dcro_fcw_ctrl #(
    .SEL_LEN   (8),
    .STEP_LEN  (4),
    .MIN_VALUE (1),
    .MAX_VALUE (255),
    .RST_VALUE (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel_in   (sel_in),
    .max_step (max_step),
    .abort    (abort),
    .sel_out  (sel_out),
    .busy     (busy),
    .sat_hi   (sat_hi),
    .sat_lo   (sat_lo),
    .settled  (settled)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input int sel, input logic rdy, input logic bsy,
                              input logic hi, input logic lo, input logic st);
    obs_t o;
    o.sel = sel[7:0];
    o.ready = rdy;
    o.busy = bsy;
    o.hi = hi;
    o.lo = lo;
    o.settled = st;
    return o;
  endfunction

  function automatic step_t st(input logic v, input logic [1:0] md, input int si,
                               input int ms, input logic ab, input logic r, input obs_t e);
    step_t s;
    s.v = v; s.md = md; s.si = si; s.ms = ms; s.ab = ab; s.r = r; s.e = e;
    return s;
  endfunction

  task automatic drive(input step_t s);
    rst      = s.r;
    in_valid = s.v;
    mode     = s.md;
    sel_in   = s.si[8:0];
    max_step = s.ms[3:0];
    abort    = s.ab;
    sb.push_back(s.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    obs_t got, exp;
    s.push_back(st(0, MODE_HOLD, 0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 0, 0, mk(1, 1, 0, 0, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      got = {sel_out, in_ready, busy, sat_hi, sat_lo, settled};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset[%0d]: got sel=%0d rdy=%b busy=%b hi=%b lo=%b st=%b, need sel=%0d rdy=%b busy=%b hi=%b lo=%b st=%b",
                 i, got.sel, got.ready, got.busy, got.hi, got.lo, got.settled,
                 exp.sel, exp.ready, exp.busy, exp.hi, exp.lo, exp.settled);
      end
    end
  endtask

  task automatic test_abs();
    step_t s[$];
    obs_t got, exp;
    s.push_back(st(1, MODE_ABS, 100, 0, 0, 0, mk(100, 1, 0, 0, 0, 0)));
    s.push_back(st(1, MODE_ABS, -5, 0, 0, 0, mk(1, 1, 0, 0, 1, 0)));
    s.push_back(st(1, MODE_ABS, 255, 0, 0, 0, mk(255, 1, 0, 0, 0, 0)));
    s.push_back(st(0, MODE_ABS, 0, 0, 0, 0, mk(255, 1, 0, 0, 0, 0)));
    s.push_back(st(1, MODE_ABS, -256, 0, 0, 0, mk(1, 1, 0, 0, 1, 0)));
    s.push_back(st(1, MODE_ABS, 0, 0, 0, 0, mk(1, 1, 0, 0, 1, 0)));
    s.push_back(st(1, MODE_ABS, 1, 0, 0, 0, mk(1, 1, 0, 0, 0, 0)));
    s.push_back(st(1, MODE_HOLD, 77, 0, 0, 0, mk(1, 1, 0, 0, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      got = {sel_out, in_ready, busy, sat_hi, sat_lo, settled};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abs[%0d]: got sel=%0d rdy=%b busy=%b hi=%b lo=%b st=%b, need sel=%0d rdy=%b busy=%b hi=%b lo=%b st=%b",
                 i, got.sel, got.ready, got.busy, got.hi, got.lo, got.settled,
                 exp.sel, exp.ready, exp.busy, exp.hi, exp.lo, exp.settled);
      end
    end
  endtask

  task automatic test_back_to_back_inc();
    step_t s[$];
    obs_t got, exp;
    s.push_back(st(1, MODE_ABS, 250, 0, 0, 0, mk(250, 1, 0, 0, 0, 0)));
    s.push_back(st(1, MODE_INC, 10, 0, 0, 0, mk(255, 1, 0, 1, 0, 0)));
    s.push_back(st(1, MODE_ABS, 10, 0, 0, 0, mk(10, 1, 0, 0, 0, 0)));
    for (int k = 1; k <= 5; k++)
      s.push_back(st(1, MODE_INC, 1, 0, 0, 0, mk(10 + k, 1, 0, 0, 0, 0)));
    s.push_back(st(1, MODE_INC, -3, 0, 0, 0, mk(12, 1, 0, 0, 0, 0)));
    s.push_back(st(1, MODE_INC, -20, 0, 0, 0, mk(1, 1, 0, 0, 1, 0)));
    s.push_back(st(1, MODE_INC, 255, 0, 0, 0, mk(255, 1, 0, 1, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      got = {sel_out, in_ready, busy, sat_hi, sat_lo, settled};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL inc[%0d]: got sel=%0d rdy=%b busy=%b hi=%b lo=%b st=%b, need sel=%0d rdy=%b busy=%b hi=%b lo=%b st=%b",
                 i, got.sel, got.ready, got.busy, got.hi, got.lo, got.settled,
                 exp.sel, exp.ready, exp.busy, exp.hi, exp.lo, exp.settled);
      end
    end
  endtask

  task automatic test_ramp();
    step_t s[$];
    obs_t got, exp;
    s.push_back(st(1, MODE_ABS, 10, 0, 0, 0, mk(10, 1, 0, 0, 0, 0)));
    s.push_back(st(1, MODE_RAMP, 40, 8, 0, 0, mk(18, 0, 1, 0, 0, 0)));
    s.push_back(st(1, MODE_ABS, 0, 0, 0, 0, mk(26, 0, 1, 0, 0, 0)));
    s.push_back(st(1, MODE_ABS, 0, 0, 0, 0, mk(34, 0, 1, 0, 0, 0)));
    s.push_back(st(1, MODE_ABS, 0, 0, 0, 0, mk(40, 1, 0, 0, 0, 1)));
    s.push_back(st(0, MODE_ABS, 0, 0, 0, 0, mk(40, 1, 0, 0, 0, 0)));
    s.push_back(st(1, MODE_RAMP, 33, 4, 0, 0, mk(36, 0, 1, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 0, 0, mk(33, 1, 0, 0, 0, 1)));
    foreach (s[i]) begin
      drive(s[i]);
      got = {sel_out, in_ready, busy, sat_hi, sat_lo, settled};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ramp[%0d]: got sel=%0d rdy=%b busy=%b hi=%b lo=%b st=%b, need sel=%0d rdy=%b busy=%b hi=%b lo=%b st=%b",
                 i, got.sel, got.ready, got.busy, got.hi, got.lo, got.settled,
                 exp.sel, exp.ready, exp.busy, exp.hi, exp.lo, exp.settled);
      end
    end
  endtask

  task automatic test_abort_reset();
    step_t s[$];
    obs_t got, exp;
    s.push_back(st(1, MODE_ABS, 10, 0, 0, 0, mk(10, 1, 0, 0, 0, 0)));
    s.push_back(st(1, MODE_RAMP, 200, 15, 0, 0, mk(25, 0, 1, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 0, 0, mk(40, 0, 1, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 0, 0, mk(55, 0, 1, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 1, 0, mk(55, 1, 0, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 0, 0, mk(55, 1, 0, 0, 0, 0)));
    s.push_back(st(1, MODE_RAMP, 200, 15, 0, 0, mk(70, 0, 1, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 0, 0, mk(85, 0, 1, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 0, 0, mk(1, 1, 0, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 1, 0, mk(1, 1, 0, 0, 0, 0)));
    s.push_back(st(1, MODE_RAMP, 5, 2, 0, 0, mk(3, 0, 1, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 1, 0, mk(3, 1, 0, 0, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      got = {sel_out, in_ready, busy, sat_hi, sat_lo, settled};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abort[%0d]: got sel=%0d rdy=%b busy=%b hi=%b lo=%b st=%b, need sel=%0d rdy=%b busy=%b hi=%b lo=%b st=%b",
                 i, got.sel, got.ready, got.busy, got.hi, got.lo, got.settled,
                 exp.sel, exp.ready, exp.busy, exp.hi, exp.lo, exp.settled);
      end
    end
  endtask

  task automatic test_ramp_edges();
    step_t s[$];
    obs_t got, exp;
    s.push_back(st(1, MODE_ABS, 5, 0, 0, 0, mk(5, 1, 0, 0, 0, 0)));
    s.push_back(st(1, MODE_RAMP, 8, 0, 0, 0, mk(6, 0, 1, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 0, 0, mk(7, 0, 1, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 0, 0, mk(8, 1, 0, 0, 0, 1)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 0, 0, mk(8, 1, 0, 0, 0, 0)));
    s.push_back(st(1, MODE_RAMP, 8, 3, 0, 0, mk(8, 1, 0, 0, 0, 1)));
    s.push_back(st(1, MODE_RAMP, -3, 15, 0, 0, mk(1, 1, 0, 0, 1, 1)));
    s.push_back(st(1, MODE_RAMP, 255, 15, 1, 0, mk(16, 0, 1, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 0, 0, mk(31, 0, 1, 0, 0, 0)));
    s.push_back(st(0, MODE_HOLD, 0, 0, 1, 0, mk(31, 1, 0, 0, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      got = {sel_out, in_ready, busy, sat_hi, sat_lo, settled};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ramp_edge[%0d]: got sel=%0d rdy=%b busy=%b hi=%b lo=%b st=%b, need sel=%0d rdy=%b busy=%b hi=%b lo=%b st=%b",
                 i, got.sel, got.ready, got.busy, got.hi, got.lo, got.settled,
                 exp.sel, exp.ready, exp.busy, exp.hi, exp.lo, exp.settled);
      end
    end
  endtask

  initial begin
    test_reset();
    test_abs();
    test_back_to_back_inc();
    test_ramp();
    test_abort_reset();
    test_ramp_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
